// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped 2-bit counters plus tagged BTB, trained by execute.
// Optional macro BP_PERF_CNT_EN adds perf_updates / perf_mispredicts counters and ports.
module branch_predictor #(
  parameter int ENTRIES    = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [DATA_WIDTH-1:0] upd_target,
`ifdef BP_PERF_CNT_EN
  input  logic                  upd_pred_taken,
  output logic [31:0]           perf_updates,
  output logic [31:0]           perf_mispredicts
`else
  input  logic                  upd_pred_taken
`endif
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX - 2;

  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [TAG_W-1:0]      tag_d    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];
  logic [DATA_WIDTH-1:0] target_d [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [1:0]            ctr_d    [ENTRIES];

  logic [IDX-1:0]   if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             if_hit, upd_hit;

  assign if_idx  = if_pc[IDX+1:2];
  assign if_tag  = if_pc[DATA_WIDTH-1:IDX+2];
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[DATA_WIDTH-1:IDX+2];

  // Lookup reads registered state only, so a same-cycle update is never bypassed.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = rst_n && if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : '0;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          target_d[upd_idx] = upd_target;
          if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Only taken branches allocate; a fresh entry starts weakly taken.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_updates_q, perf_updates_d;
  logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

  always_comb begin
    perf_updates_d     = perf_updates_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (upd_valid) begin
      perf_updates_d = perf_updates_q + 32'd1;
      if (upd_pred_taken != upd_taken) perf_mispredicts_d = perf_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_updates_q     <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_updates_q     <= perf_updates_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_updates     = perf_updates_q;
  assign perf_mispredicts = perf_mispredicts_q;
`else
  logic unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken;
`endif

endmodule
